// File: rtl/ram_sp_param_if.sv
// Access bus between the CPU control unit and ram_sp_param.
// master = requester (control unit), slave = the RAM.
interface ram_sp_param_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              ce;
  logic              enable;
  logic              r_w;
  logic [ADDR_W-1:0] add;
  logic [DATA_W-1:0] data_in;
  logic              clr;
  logic              err_inj;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              ready;
  logic              parity_err;

  modport master (
    output ce, enable, r_w, add, data_in, clr, err_inj,
    input  data_out, rd_valid, ready, parity_err
  );

  modport slave (
    input  ce, enable, r_w, add, data_in, clr, err_inj,
    output data_out, rd_valid, ready, parity_err
  );
endinterface

// File: rtl/ram_sp_param.sv
// Single-port sync RAM with clear sweep; optional parity under RAM_SP_PARITY_EN.
// Latency: read data and rd_valid one cycle after the accepting edge.
// Backpressure: ready=0 during clear sweep; requests then are dropped, not stalled.
module ram_sp_param #(
  parameter int              ADDR_W         = 6,
  parameter int              DATA_W         = 16,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
  input logic           clk,
  input logic           rst_n,
  ram_sp_param_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_SP_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic              ready_q;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] wr_dat;
  logic              wr_inj;
  logic [MEM_W-1:0]  mem_wd;
  logic [MEM_W-1:0]  rd_word;

  // clr wins over any access arriving on the same edge
  logic access;
  assign access = (state == ST_IDLE) && bus.enable && !bus.clr;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = ptr;
    wr_dat = INIT_VAL;
    wr_inj = 1'b0;
    if (bus.ce) begin
      if (state == ST_CLEAR) begin
        mem_we = 1'b1;
      end else if (access && bus.r_w) begin
        mem_we = 1'b1;
        mem_wa = bus.add;
        wr_dat = bus.data_in;
        wr_inj = bus.err_inj;
      end
    end
  end

`ifdef RAM_SP_PARITY_EN
  assign mem_wd = {(^wr_dat) ^ wr_inj, wr_dat};
`else
  logic unused_wr_inj;
  assign unused_wr_inj = wr_inj;
  assign mem_wd        = wr_dat;
`endif

  // Array deliberately has no reset; the sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rd_word = mem[bus.add];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr        <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= !CLEAR_ON_RESET;
    end else if (bus.ce) begin
      case (state)
        ST_CLEAR: begin
          rd_valid_q <= 1'b0;
          if (bus.clr) begin
            ptr <= '0;
          end else begin
            ptr <= ptr + 1'b1;
            if (ptr == ADDR_W'(DEPTH - 1)) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.clr) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
          end else if (access && !bus.r_w) begin
            data_out_q <= rd_word[DATA_W-1:0];
            rd_valid_q <= 1'b1;
          end else begin
            rd_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef RAM_SP_PARITY_EN
  logic parity_err_q;

  // Recomputed parity over data plus stored bit: nonzero means corruption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (bus.ce && access && !bus.r_w) begin
      parity_err_q <= ^rd_word;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ready    = ready_q;

endmodule
